mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares a single memory port between the instruction-fetch bus (ibus) and the data bus (dbus).
- Sits between the fetch/memory pipeline stages and the core's external memory interface.
- Each transaction is single-beat and is latched at grant.
- The memory side sees a stable request until it acknowledges.
- The response goes only to the requester that was granted. A stale ibus response, left behind by a redirect, is discarded.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- WAIT_MAX, 4, number of consecutive dbus grants while ibus is pending before ibus is forced to win (fixed-priority mode).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireq_valid  in  1  fetch request.
- ireq_addr  in  ADDR_W  fetch address.
- iresp_data_ok  out  1  one-cycle pulse: iresp_data valid.
- iresp_data  out  DATA_W  fetched data.
- dreq_valid  in  1  data request; held until dresp_data_ok.
- dreq_addr  in  ADDR_W  data address.
- dreq_write  in  1  1 = store.
- dreq_size  in  3  log2 bytes.
- dreq_strobe  in  DATA_W/8  byte enables for a store.
- dreq_data  in  DATA_W  store data.
- dresp_data_ok  out  1  one-cycle pulse: load data valid / store done.
- dresp_data  out  DATA_W  load data.
- mreq_valid  out  1  memory request.
- mreq_addr  out  ADDR_W  memory address.
- mreq_write  out  1  memory write.
- mreq_size  out  3  access size.
- mreq_strobe  out  DATA_W/8  byte enables.
- mreq_data  out  DATA_W  write data.
- mresp_ok  in  1  memory completes the held request this cycle.
- mresp_data  in  DATA_W  read data, valid with mresp_ok.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (on reset low, asynchronous):
  - State = IDLE.
  - mreq_valid, iresp_data_ok, dresp_data_ok, busy = 0.
  - All latched fields and data outputs = 0.
  - Wait counter = 0.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, arbitration each cycle:
  - Only one valid: grant it.
  - Both valid: grant dbus, unless the wait counter == WAIT_MAX, then grant ibus.
  - On grant, latch addr/write/size/strobe/data and the owner (ibus: write=0, size=3, strobe=0).
  - Go to BUSY_I or BUSY_D.
- BUSY_x:
  - mreq_valid=1; mreq_* driven from latched registers only, stable until mresp_ok.
  - On mresp_ok: latch mresp_data, go to RESP.
- RESP (one cycle):
  - dbus owner: dresp_data_ok=1, with the latched data.
  - ibus owner: iresp_data_ok = ireq_valid && ireq_addr == latched addr.
  - On a mismatch the response is silently dropped. Fetch was redirected and re-requests.
  - Next state: IDLE.
- The RESP cycle keeps a requester's old request from being re-granted in the same cycle it receives data_ok.
- Latency: request seen in IDLE at cycle N → mreq_valid from N+1. mresp_ok at M → data_ok at M+1 → IDLE at M+2.
- Wait counter:
  - Increments on each dbus grant made while ireq_valid=1; saturates at WAIT_MAX.
  - Clears on an ibus grant or whenever ireq_valid=0 in IDLE.
- Simultaneous events:
  - The ibus request may drop or change address during BUSY_I. The transaction still completes (no abort to memory) and is filtered in RESP.
  - mresp_ok while IDLE/RESP is ignored.
- dbus must hold its request until dresp_data_ok. If it does not, the pulse is still issued.
- Reset mid-transaction: immediate return to IDLE and mreq_valid deasserted. No data_ok is issued for the abandoned request.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are valid in IDLE, grant the one that was not the owner of the last completed grant. The wait counter and WAIT_MAX are unused, and the counter stays 0. The first contention after reset goes to dbus.
- Undefined: fixed dbus priority with the WAIT_MAX anti-starvation rule described above.

Decomposition:
- Shared package:
  - `arb_state_t` enum (IDLE, BUSY_I, BUSY_D, RESP).
  - `arb_owner_t` (OWN_I, OWN_D).
  - Latched-request struct `mreq_latch_t` {addr, write, size, strobe, data}.
  - Reset vector constants for the address fields.
- One natural sub-module, `arb_pick`: combinational grant selection (fixed/starvation or round-robin under the macro). It takes both valids, the wait counter and the last owner, and returns the grant plus owner.

Test Plan:
- ibus only, addr 0x80000000; mresp_ok 3 cycles after mreq_valid, data 0x13 → iresp_data_ok pulse one cycle after mresp_ok; iresp_data=0x13; mreq_valid high exactly 3 cycles.
- Both valid at once, dbus store addr 0x80001000 strobe 0xFF → dbus granted first (mreq_write=1); ibus granted after the dbus RESP cycle; no overlap of mreq transactions.
- dbus held continuously with ibus pending, WAIT_MAX=4 → grants D,D,D,D,I; the counter clears after the ibus grant.
- During BUSY_I, ireq_addr changes 0x80000004→0x80000100 before mresp_ok → no iresp_data_ok for that transaction; next grant fetches 0x80000100.
- reset driven low in BUSY_D, asynchronously mid-cycle → mreq_valid=0 and busy=0 immediately, without waiting for a clock edge; no dresp_data_ok after release.
- With ARB_ROUND_ROBIN_EN, both held valid → grants alternate D,I,D,I; mreq fields stable while mresp_ok=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory-port arbiter.
// Optional build macro used by this slice: ARB_ROUND_ROBIN_EN.
package mem_bus_arbiter_pkg;

    // The latched-request struct is sized for the widest supported port;
    // narrower instances zero-extend on latch and slice on output.
    localparam int ARB_ADDR_W_MAX = 64;
    localparam int ARB_DATA_W_MAX = 64;
    localparam int ARB_STRB_W_MAX = ARB_DATA_W_MAX / 8;

    // Reset vectors for the address fields.
    localparam logic [ARB_ADDR_W_MAX-1:0] ARB_ADDR_RST = '0;

    // Fetches are always full-width reads.
    localparam logic [2:0] ARB_IBUS_SIZE = 3'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [ARB_ADDR_W_MAX-1:0] addr;
        logic                      write;
        logic [2:0]                size;
        logic [ARB_STRB_W_MAX-1:0] strobe;
        logic [ARB_DATA_W_MAX-1:0] data;
    } mreq_latch_t;

    localparam mreq_latch_t MREQ_LATCH_RST = '{
        addr:   ARB_ADDR_RST,
        write:  1'b0,
        size:   3'd0,
        strobe: '0,
        data:   '0
    };

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational grant selection between ibus and dbus.
// Default: dbus priority with an anti-starvation override once ibus has
// lost WAIT_MAX consecutive arbitrations. With ARB_ROUND_ROBIN_EN defined,
// contention goes to whichever side did not own the last completed grant.
module arb_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic             ivalid,
    input  logic             dvalid,
    input  logic [CNT_W-1:0] wait_cnt,
    input  arb_owner_t       last_owner,
    output logic             grant,
    output arb_owner_t       owner
);

`ifdef ARB_ROUND_ROBIN_EN
    // The starvation counter has no role when alternating.
    logic unused_wait_cnt;
    assign unused_wait_cnt = ^wait_cnt;

    // Alternate on contention; a lone requester always wins.
    always_comb begin
        grant = ivalid | dvalid;
        owner = OWN_D;
        if (ivalid && !dvalid) begin
            owner = OWN_I;
        end else if (ivalid && dvalid) begin
            owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end
    end
`else
    // History is irrelevant under fixed priority.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // dbus wins contention unless ibus has waited WAIT_MAX grants.
    always_comb begin
        grant = ivalid | dvalid;
        owner = OWN_D;
        if (ivalid && !dvalid) begin
            owner = OWN_I;
        end else if (ivalid && dvalid && (wait_cnt == CNT_W'(WAIT_MAX))) begin
            owner = OWN_I;
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (ibus) and the
// data bus (dbus). One single-beat transaction at a time: the request is
// latched at grant, held on the memory side until mresp_ok, and the reply
// is routed back only to the owner. A fetch reply whose address no longer
// matches the live ibus request is dropped (fetch was redirected).
// Optional build macro: ARB_ROUND_ROBIN_EN (alternating arbitration).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_data_ok,
    output logic [DATA_W-1:0] iresp_data,

    input  logic                dreq_valid,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic                dreq_write,
    input  logic [2:0]          dreq_size,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_data,
    output logic                dresp_data_ok,
    output logic [DATA_W-1:0]   dresp_data,

    output logic                mreq_valid,
    output logic [ADDR_W-1:0]   mreq_addr,
    output logic                mreq_write,
    output logic [2:0]          mreq_size,
    output logic [DATA_W/8-1:0] mreq_strobe,
    output logic [DATA_W-1:0]   mreq_data,
    input  logic                mresp_ok,
    input  logic [DATA_W-1:0]   mresp_data,

    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    arb_owner_t        owner_q;
    arb_owner_t        last_owner_q;
    mreq_latch_t       lat_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    logic              grant;
    arb_owner_t        pick_owner;
    logic              arb_now;
    logic              ibus_match;

`ifndef ARB_ROUND_ROBIN_EN
    // Saturating increment for the ibus wait counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_W'(WAIT_MAX)) begin
            return CNT_W'(WAIT_MAX);
        end
        return v + CNT_W'(1);
    endfunction
`endif

    arb_pick #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_pick (
        .ivalid     (ireq_valid),
        .dvalid     (dreq_valid),
        .wait_cnt   (wait_cnt_q),
        .last_owner (last_owner_q),
        .grant      (grant),
        .owner      (pick_owner)
    );

    assign arb_now    = (state_q == IDLE) && grant;
    assign ibus_match = ireq_valid && (ireq_addr == lat_q.addr[ADDR_W-1:0]);

    // Memory side is driven purely from the latch so it cannot move mid-request.
    assign mreq_addr   = lat_q.addr[ADDR_W-1:0];
    assign mreq_write  = lat_q.write;
    assign mreq_size   = lat_q.size;
    assign mreq_strobe = lat_q.strobe[STRB_W-1:0];
    assign mreq_data   = lat_q.data[DATA_W-1:0];
    assign iresp_data  = rdata_q;
    assign dresp_data  = rdata_q;

    // State register; async reset abandons any in-flight request at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        mreq_valid    = 1'b0;
        iresp_data_ok = 1'b0;
        dresp_data_ok = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = (pick_owner == OWN_I) ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                mreq_valid = 1'b1;
                if (mresp_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Extra cycle so the owner can drop its request before rearbitration.
                if (owner_q == OWN_D) begin
                    dresp_data_ok = 1'b1;
                end else begin
                    iresp_data_ok = ibus_match;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the winning request and its owner at grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_q   <= MREQ_LATCH_RST;
            owner_q <= OWN_I;
        end else if (arb_now) begin
            owner_q <= pick_owner;
            if (pick_owner == OWN_I) begin
                lat_q.addr   <= ARB_ADDR_W_MAX'(ireq_addr);
                lat_q.write  <= 1'b0;
                lat_q.size   <= ARB_IBUS_SIZE;
                lat_q.strobe <= '0;
                lat_q.data   <= '0;
            end else begin
                lat_q.addr   <= ARB_ADDR_W_MAX'(dreq_addr);
                lat_q.write  <= dreq_write;
                lat_q.size   <= dreq_size;
                lat_q.strobe <= ARB_STRB_W_MAX'(dreq_strobe);
                lat_q.data   <= ARB_DATA_W_MAX'(dreq_data);
            end
        end
    end

    // Hold read data from the completing memory cycle for the RESP pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (((state_q == BUSY_I) || (state_q == BUSY_D)) && mresp_ok) begin
            rdata_q <= mresp_data;
        end
    end

    // Remember who owned the last completed grant (dbus wins first contention).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= OWN_I;
        end else if (state_q == RESP) begin
            last_owner_q <= owner_q;
        end
    end

    // Count dbus wins while ibus is waiting; clear once ibus is served or idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            wait_cnt_q <= '0;
`else
            if (state_q == IDLE) begin
                if (!ireq_valid) begin
                    wait_cnt_q <= '0;
                end else if (grant && (pick_owner == OWN_I)) begin
                    wait_cnt_q <= '0;
                end else if (grant && (pick_owner == OWN_D)) begin
                    wait_cnt_q <= sat_inc(wait_cnt_q);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid = 1'b0;
    logic [63:0] ireq_addr = '0;
    logic        iresp_data_ok;
    logic [63:0] iresp_data;
    logic        dreq_valid = 1'b0;
    logic [63:0] dreq_addr = '0;
    logic        dreq_write = 1'b0;
    logic [2:0]  dreq_size = '0;
    logic [7:0]  dreq_strobe = '0;
    logic [63:0] dreq_data = '0;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        mreq_valid;
    logic [63:0] mreq_addr;
    logic        mreq_write;
    logic [2:0]  mreq_size;
    logic [7:0]  mreq_strobe;
    logic [63:0] mreq_data;
    logic        mresp_ok = 1'b0;
    logic [63:0] mresp_data = '0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Captured view of one memory transaction.
    int          cap_wait;
    int          cap_hi;
    logic        cap_w;
    logic [63:0] cap_a;
    logic [2:0]  cap_sz;
    logic [7:0]  cap_st;
    logic [63:0] cap_d;
    logic        cap_stable;
    logic        cap_iok;
    logic        cap_dok;
    logic [63:0] cap_idat;
    logic [63:0] cap_ddat;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .WAIT_MAX (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_write    (dreq_write),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .mreq_valid    (mreq_valid),
        .mreq_addr     (mreq_addr),
        .mreq_write    (mreq_write),
        .mreq_size     (mreq_size),
        .mreq_strobe   (mreq_strobe),
        .mreq_data     (mreq_data),
        .mresp_ok      (mresp_ok),
        .mresp_data    (mresp_data),
        .busy          (busy)
    );

    // Memory model: wait for a request, complete it on its lat-th cycle,
    // and return at the falling edge of the RESP cycle.
    task automatic serve(input int lat, input logic [63:0] rdata,
                         input logic chg, input logic [63:0] naddr);
        int guard;
        guard = 0;
        cap_hi = 0;
        cap_stable = 1'b1;
        while (mreq_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        cap_wait = guard;
        checks++;
        if (mreq_valid !== 1'b1) begin
            failures++;
            $display("FAIL serve_timeout: mreq_valid=%b required 1", mreq_valid);
        end
        cap_w  = mreq_write;
        cap_a  = mreq_addr;
        cap_sz = mreq_size;
        cap_st = mreq_strobe;
        cap_d  = mreq_data;
        while (mreq_valid === 1'b1 && cap_hi < 20) begin
            cap_hi++;
            if (mreq_write !== cap_w || mreq_addr !== cap_a || mreq_size !== cap_sz ||
                mreq_strobe !== cap_st || mreq_data !== cap_d)
                cap_stable = 1'b0;
            if (cap_hi == 1 && chg) ireq_addr = naddr;
            if (cap_hi == lat) begin
                mresp_ok = 1'b1;
                mresp_data = rdata;
            end
            @(negedge clk);
            mresp_ok = 1'b0;
        end
        cap_iok  = iresp_data_ok;
        cap_dok  = dresp_data_ok;
        cap_idat = iresp_data;
        cap_ddat = dresp_data;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mreq_valid !== 1'b0) begin failures++; $display("FAIL rst_mreq_valid: got %b want 0", mreq_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (iresp_data_ok !== 1'b0) begin failures++; $display("FAIL rst_iok: got %b want 0", iresp_data_ok); end
        checks++; if (dresp_data_ok !== 1'b0) begin failures++; $display("FAIL rst_dok: got %b want 0", dresp_data_ok); end
        checks++; if (mreq_addr !== 64'h0) begin failures++; $display("FAIL rst_mreq_addr: got %h want 0", mreq_addr); end
        checks++; if (iresp_data !== 64'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", iresp_data); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ibus_only();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0000;
        serve(3, 64'h13, 1'b0, 64'h0);
        ireq_valid = 1'b0;
        checks++; if (cap_wait !== 1) begin failures++; $display("FAIL ibus_latency: got %0d want 1", cap_wait); end
        checks++; if (cap_hi !== 3) begin failures++; $display("FAIL ibus_mreq_cycles: got %0d want 3", cap_hi); end
        checks++; if (cap_a !== 64'h8000_0000) begin failures++; $display("FAIL ibus_addr: got %h want 80000000", cap_a); end
        checks++; if (cap_w !== 1'b0) begin failures++; $display("FAIL ibus_write: got %b want 0", cap_w); end
        checks++; if (cap_sz !== 3'd3) begin failures++; $display("FAIL ibus_size: got %0d want 3", cap_sz); end
        checks++; if (cap_st !== 8'h00) begin failures++; $display("FAIL ibus_strobe: got %h want 00", cap_st); end
        checks++; if (cap_iok !== 1'b1) begin failures++; $display("FAIL ibus_iok: got %b want 1", cap_iok); end
        checks++; if (cap_dok !== 1'b0) begin failures++; $display("FAIL ibus_dok: got %b want 0", cap_dok); end
        checks++; if (cap_idat !== 64'h13) begin failures++; $display("FAIL ibus_data: got %h want 13", cap_idat); end
        @(negedge clk);
        checks++; if (iresp_data_ok !== 1'b0) begin failures++; $display("FAIL ibus_pulse_len: got %b want 0", iresp_data_ok); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ibus_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_both_valid();
        ireq_valid  = 1'b1;
        ireq_addr   = 64'h8000_2000;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8000_1000;
        dreq_write  = 1'b1;
        dreq_size   = 3'd3;
        dreq_strobe = 8'hFF;
        dreq_data   = 64'hDEAD_BEEF_0123_4567;
        serve(2, 64'h0, 1'b0, 64'h0);
        dreq_valid = 1'b0;
        checks++; if (cap_w !== 1'b1) begin failures++; $display("FAIL both_d_write: got %b want 1", cap_w); end
        checks++; if (cap_a !== 64'h8000_1000) begin failures++; $display("FAIL both_d_addr: got %h want 80001000", cap_a); end
        checks++; if (cap_st !== 8'hFF) begin failures++; $display("FAIL both_d_strobe: got %h want ff", cap_st); end
        checks++; if (cap_d !== 64'hDEAD_BEEF_0123_4567) begin failures++; $display("FAIL both_d_data: got %h want deadbeef01234567", cap_d); end
        checks++; if (cap_stable !== 1'b1) begin failures++; $display("FAIL both_d_stable: got %b want 1", cap_stable); end
        checks++; if (cap_dok !== 1'b1) begin failures++; $display("FAIL both_d_dok: got %b want 1", cap_dok); end
        checks++; if (cap_iok !== 1'b0) begin failures++; $display("FAIL both_d_iok: got %b want 0", cap_iok); end
        serve(2, 64'h55AA, 1'b0, 64'h0);
        ireq_valid = 1'b0;
        checks++; if (cap_wait !== 2) begin failures++; $display("FAIL both_gap: got %0d want 2", cap_wait); end
        checks++; if (cap_w !== 1'b0) begin failures++; $display("FAIL both_i_write: got %b want 0", cap_w); end
        checks++; if (cap_a !== 64'h8000_2000) begin failures++; $display("FAIL both_i_addr: got %h want 80002000", cap_a); end
        checks++; if (cap_iok !== 1'b1) begin failures++; $display("FAIL both_i_iok: got %b want 1", cap_iok); end
        checks++; if (cap_idat !== 64'h55AA) begin failures++; $display("FAIL both_i_data: got %h want 55aa", cap_idat); end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic exp_i;
        ireq_valid  = 1'b1;
        ireq_addr   = 64'h8000_0040;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h9000_0000;
        dreq_write  = 1'b0;
        dreq_size   = 3'd2;
        dreq_strobe = 8'h00;
        dreq_data   = 64'h0;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_i = (k % 2) == 1;
`else
            exp_i = (k % 5) == 4;
`endif
            serve(2, 64'h100 + 64'(k), 1'b0, 64'h0);
            checks++;
            if (cap_a !== (exp_i ? 64'h8000_0040 : 64'h9000_0000)) begin
                failures++;
                $display("FAIL starve_grant%0d: addr got %h want %h", k, cap_a, exp_i ? 64'h8000_0040 : 64'h9000_0000);
            end
            checks++;
            if ({cap_iok, cap_dok} !== {exp_i, ~exp_i}) begin
                failures++;
                $display("FAIL starve_resp%0d: iok/dok got %b%b want %b%b", k, cap_iok, cap_dok, exp_i, ~exp_i);
            end
            checks++;
            if (cap_stable !== 1'b1) begin failures++; $display("FAIL starve_stable%0d: got %b want 1", k, cap_stable); end
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_redirect();
        ireq_valid = 1'b1;
        ireq_addr  = 64'h8000_0004;
        serve(3, 64'hAAAA, 1'b1, 64'h8000_0100);
        checks++; if (cap_a !== 64'h8000_0004) begin failures++; $display("FAIL redir_old_addr: got %h want 80000004", cap_a); end
        checks++; if (cap_stable !== 1'b1) begin failures++; $display("FAIL redir_stable: got %b want 1", cap_stable); end
        checks++; if (cap_iok !== 1'b0) begin failures++; $display("FAIL redir_stale_drop: got %b want 0", cap_iok); end
        serve(2, 64'hBBBB, 1'b0, 64'h0);
        ireq_valid = 1'b0;
        checks++; if (cap_a !== 64'h8000_0100) begin failures++; $display("FAIL redir_new_addr: got %h want 80000100", cap_a); end
        checks++; if (cap_iok !== 1'b1) begin failures++; $display("FAIL redir_new_iok: got %b want 1", cap_iok); end
        checks++; if (cap_idat !== 64'hBBBB) begin failures++; $display("FAIL redir_new_data: got %h want bbbb", cap_idat); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int guard;
        dreq_valid  = 1'b1;
        dreq_addr   = 64'h8000_3000;
        dreq_write  = 1'b1;
        dreq_size   = 3'd3;
        dreq_strobe = 8'h0F;
        dreq_data   = 64'h1234;
        guard = 0;
        while (mreq_valid !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (mreq_valid !== 1'b1) begin failures++; $display("FAIL rmid_busy_d: mreq_valid got %b want 1", mreq_valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (mreq_valid !== 1'b0) begin failures++; $display("FAIL rmid_mreq_async: got %b want 0", mreq_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy_async: got %b want 0", busy); end
        dreq_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mresp_ok = 1'b1;
        mresp_data = 64'hFFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mresp_ok = 1'b0;
            checks++; if (dresp_data_ok !== 1'b0) begin failures++; $display("FAIL rmid_no_dok%0d: got %b want 0", c, dresp_data_ok); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_idle%0d: busy got %b want 0", c, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_ibus_only();
        test_both_valid();
        test_starvation();
        test_redirect();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
